mem_arb: RTL and testbench

MEM_ARB -- requirements
Module: mem_arb

---
 rtl/mem_arb_pkg.sv | 18 +
 rtl/mem_arb_if.sv | 44 ++++
 rtl/mem_arb_cnt.sv | 31 +++
 rtl/mem_arb.sv | 142 ++++++++++++++
 tb/tb_mem_arb.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the instruction/data memory-port arbiter:
// state encoding, default limits and a counter sizing helper.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GNT_D = 2'd1,
      ST_GNT_I = 2'd2
   } arb_state_e;

   localparam int DEF_TIMEOUT = 16;
   localparam int DEF_STARVE  = 4;

   function automatic int cnt_width(input int max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/mem_arb_if.sv
// Pipeline-side requests and shared memory-port command/response bundle.
// slave = arbiter view, master = pipeline/memory environment view.
interface mem_arb_if #(
   parameter int WIDTH = 32
) ();

   logic             MEMARB_IfReq;
   logic [WIDTH-1:0] MEMARB_IfAddr;
   logic             MEMARB_MemWriteM;
   logic             MEMARB_MemToRegM;
   logic [WIDTH-1:0] MEMARB_AluOutM;
   logic [WIDTH-1:0] MEMARB_WriteDataM;
   logic             MEMARB_MemAck;
   logic [WIDTH-1:0] MEMARB_MemRdata;

   logic             MEMARB_MemReq;
   logic             MEMARB_MemWe;
   logic [WIDTH-1:0] MEMARB_MemAddr;
   logic [WIDTH-1:0] MEMARB_MemWdata;
   logic             MEMARB_IfDone;
   logic             MEMARB_DDone;
   logic [WIDTH-1:0] MEMARB_IfRdata;
   logic [WIDTH-1:0] MEMARB_DRdata;
   logic             MEMARB_StallF;
   logic             MEMARB_StallM;
   logic             MEMARB_Err;

   modport slave (
      input  MEMARB_IfReq, MEMARB_IfAddr, MEMARB_MemWriteM, MEMARB_MemToRegM,
             MEMARB_AluOutM, MEMARB_WriteDataM, MEMARB_MemAck, MEMARB_MemRdata,
      output MEMARB_MemReq, MEMARB_MemWe, MEMARB_MemAddr, MEMARB_MemWdata,
             MEMARB_IfDone, MEMARB_DDone, MEMARB_IfRdata, MEMARB_DRdata,
             MEMARB_StallF, MEMARB_StallM, MEMARB_Err
   );

   modport master (
      output MEMARB_IfReq, MEMARB_IfAddr, MEMARB_MemWriteM, MEMARB_MemToRegM,
             MEMARB_AluOutM, MEMARB_WriteDataM, MEMARB_MemAck, MEMARB_MemRdata,
      input  MEMARB_MemReq, MEMARB_MemWe, MEMARB_MemAddr, MEMARB_MemWdata,
             MEMARB_IfDone, MEMARB_DDone, MEMARB_IfRdata, MEMARB_DRdata,
             MEMARB_StallF, MEMARB_StallM, MEMARB_Err
   );

endinterface

// File: rtl/mem_arb_cnt.sv
// Saturating up-counter with synchronous clear; o_max flags the saturation value.
module mem_arb_cnt
   import mem_arb_pkg::*;
#(
   parameter int MAX = DEF_STARVE
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_clr,
   input  logic i_inc,
   output logic o_max
);

   localparam int           W     = cnt_width(MAX);
   localparam logic [W-1:0] MAX_V = W'(MAX);

   logic [W-1:0] r_cnt;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_inc && (r_cnt != MAX_V)) begin
         r_cnt <= r_cnt + W'(1);
      end
   end

   assign o_max = (r_cnt == MAX_V);

endmodule

// File: rtl/mem_arb.sv
// Arbiter sharing one memory port between instruction fetch and the memory stage.
//   state    | meaning
//   ST_IDLE  | no command on the port; pick an eligible requester
//   ST_GNT_D | data (load/store) command held until ack or timeout
//   ST_GNT_I | fetch read command held until ack or timeout
module mem_arb
   import mem_arb_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int TIMEOUT = DEF_TIMEOUT,
   parameter int STARVE  = DEF_STARVE
) (
   input  logic     MEMARB_CLK,
   input  logic     MEMARB_RST,
   mem_arb_if.slave bus
);

   arb_state_e       r_state;
   logic             r_mem_we;
   logic             r_if_done;
   logic             r_d_done;
   logic             r_err;
   logic [WIDTH-1:0] r_mem_addr;
   logic [WIDTH-1:0] r_mem_wdata;
   logic [WIDTH-1:0] r_if_rdata;
   logic [WIDTH-1:0] r_d_rdata;

   logic w_dreq;
   logic w_idle;
   logic w_gnt;
   logic w_d_elig;
   logic w_i_elig;
   logic w_pick_d;
   logic w_pick_i;
   logic w_starved;
   logic w_to_last;
   logic w_starve_clr;

   assign w_dreq   = bus.MEMARB_MemWriteM | bus.MEMARB_MemToRegM;
   assign w_idle   = (r_state == ST_IDLE);
   assign w_gnt    = ~w_idle;
   // A requester whose Done is showing is still holding its old request.
   assign w_d_elig = w_dreq & ~r_d_done;
   assign w_i_elig = bus.MEMARB_IfReq & ~r_if_done;
   assign w_pick_d = w_idle & w_d_elig & ~(w_i_elig & w_starved);
   assign w_pick_i = w_idle & w_i_elig & ~w_pick_d;

   assign w_starve_clr = ~bus.MEMARB_IfReq | w_pick_i;

   mem_arb_cnt #(.MAX(STARVE)) u_starve (
      .i_clk   (MEMARB_CLK),
      .i_rst_n (MEMARB_RST),
      .i_clr   (w_starve_clr),
      .i_inc   (w_pick_d),
      .o_max   (w_starved)
   );

   // Saturates on the last permitted grant cycle, so o_max marks the timeout cycle.
   mem_arb_cnt #(.MAX(TIMEOUT - 1)) u_timeout (
      .i_clk   (MEMARB_CLK),
      .i_rst_n (MEMARB_RST),
      .i_clr   (w_idle),
      .i_inc   (w_gnt),
      .o_max   (w_to_last)
   );

   always_ff @(posedge MEMARB_CLK or negedge MEMARB_RST) begin
      if (!MEMARB_RST) begin
         r_state     <= ST_IDLE;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_if_done   <= 1'b0;
         r_d_done    <= 1'b0;
         r_if_rdata  <= '0;
         r_d_rdata   <= '0;
         r_err       <= 1'b0;
      end else begin
         r_if_done <= 1'b0;
         r_d_done  <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_pick_d) begin
                  r_state     <= ST_GNT_D;
                  r_mem_addr  <= bus.MEMARB_AluOutM;
                  r_mem_we    <= bus.MEMARB_MemWriteM;
                  r_mem_wdata <= bus.MEMARB_WriteDataM;
               end else if (w_pick_i) begin
                  r_state     <= ST_GNT_I;
                  r_mem_addr  <= bus.MEMARB_IfAddr;
                  r_mem_we    <= 1'b0;
                  r_mem_wdata <= '0;
               end
            end
            ST_GNT_D: begin
               if (bus.MEMARB_MemAck) begin
                  r_state  <= ST_IDLE;
                  r_d_done <= 1'b1;
                  r_mem_we <= 1'b0;
                  if (!r_mem_we) begin
                     r_d_rdata <= bus.MEMARB_MemRdata;
                  end
               end else if (w_to_last) begin
                  r_state   <= ST_IDLE;
                  r_d_done  <= 1'b1;
                  r_mem_we  <= 1'b0;
                  r_d_rdata <= '0;
                  r_err     <= 1'b1;
               end
            end
            ST_GNT_I: begin
               if (bus.MEMARB_MemAck) begin
                  r_state    <= ST_IDLE;
                  r_if_done  <= 1'b1;
                  r_if_rdata <= bus.MEMARB_MemRdata;
               end else if (w_to_last) begin
                  r_state    <= ST_IDLE;
                  r_if_done  <= 1'b1;
                  r_if_rdata <= '0;
                  r_err      <= 1'b1;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.MEMARB_MemReq   = w_gnt;
   assign bus.MEMARB_MemWe    = r_mem_we;
   assign bus.MEMARB_MemAddr  = r_mem_addr;
   assign bus.MEMARB_MemWdata = r_mem_wdata;
   assign bus.MEMARB_IfDone   = r_if_done;
   assign bus.MEMARB_DDone    = r_d_done;
   assign bus.MEMARB_IfRdata  = r_if_rdata;
   assign bus.MEMARB_DRdata   = r_d_rdata;
   assign bus.MEMARB_Err      = r_err;
   assign bus.MEMARB_StallM   = w_dreq & ~r_d_done;
   assign bus.MEMARB_StallF   = (bus.MEMARB_IfReq & ~r_if_done) | (w_dreq & ~r_d_done);

endmodule

// File: tb/tb_mem_arb.sv
// Randomized and directed bench for mem_arb against a transaction-level reference model.
module tb_mem_arb;

   localparam int TIMEOUT = 16;
   localparam int STARVE  = 4;

   logic clk;
   logic rst_n;

   logic        if_req, mw, mr, ack;
   logic [31:0] if_addr, alu, wd, rdata;

   int n_chk  = 0;
   int n_pass = 0;

   // reference model: owner 0 = port free, 1 = data, 2 = fetch
   int          owner, waited, streak;
   bit          e_if_done, e_d_done, e_err, e_we;
   bit          last_if_done, last_d_done;
   logic [31:0] e_addr, e_wdata, e_if_rdata, e_d_rdata;

   mem_arb_if #(.WIDTH(32)) bus ();

   assign bus.MEMARB_IfReq      = if_req;
   assign bus.MEMARB_IfAddr     = if_addr;
   assign bus.MEMARB_MemWriteM  = mw;
   assign bus.MEMARB_MemToRegM  = mr;
   assign bus.MEMARB_AluOutM    = alu;
   assign bus.MEMARB_WriteDataM = wd;
   assign bus.MEMARB_MemAck     = ack;
   assign bus.MEMARB_MemRdata   = rdata;

   mem_arb #(.WIDTH(32), .TIMEOUT(TIMEOUT), .STARVE(STARVE)) dut (
      .MEMARB_CLK (clk),
      .MEMARB_RST (rst_n),
      .bus        (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) $display("FAIL %s: got %h expected %h", tag, obs, exp);
      else n_pass++;
   endtask

   task automatic clear_inputs();
      if_req = 0; mw = 0; mr = 0; ack = 0;
      if_addr = 0; alu = 0; wd = 0; rdata = 0;
   endtask

   task automatic model_reset();
      owner = 0; waited = 0; streak = 0;
      e_if_done = 0; e_d_done = 0; e_err = 0; e_we = 0;
      last_if_done = 0; last_d_done = 0;
      e_addr = 0; e_wdata = 0; e_if_rdata = 0; e_d_rdata = 0;
   endtask

   // One clock edge worth of arbitration rules, using the inputs seen at that edge.
   task automatic model_step();
      bit dreq, d_ok, i_ok;
      int pick;
      dreq = mw | mr;
      last_if_done = e_if_done;
      last_d_done  = e_d_done;
      e_if_done = 0;
      e_d_done  = 0;
      if (!if_req) streak = 0;
      if (owner == 0) begin
         d_ok = dreq && !last_d_done;
         i_ok = if_req && !last_if_done;
         pick = 0;
         if (d_ok && i_ok) pick = (streak == STARVE) ? 2 : 1;
         else if (d_ok)    pick = 1;
         else if (i_ok)    pick = 2;
         if (pick == 1) begin
            owner = 1; waited = 0;
            e_addr = alu; e_we = mw; e_wdata = wd;
            if (if_req && streak < STARVE) streak++;
         end else if (pick == 2) begin
            owner = 2; waited = 0;
            e_addr = if_addr; e_we = 0; e_wdata = 0;
            streak = 0;
         end
      end else begin
         waited++;
         if (ack || waited == TIMEOUT) begin
            if (owner == 1) begin
               e_d_done = 1;
               if (!ack)      e_d_rdata = 0;
               else if (!e_we) e_d_rdata = rdata;
            end else begin
               e_if_done  = 1;
               e_if_rdata = ack ? rdata : 32'h0;
            end
            if (!ack) e_err = 1;
            owner = 0;
            e_we  = 0;
         end
      end
   endtask

   task automatic check_outputs();
      chk("mem_req",  32'(bus.MEMARB_MemReq), 32'(owner != 0));
      chk("mem_we",   32'(bus.MEMARB_MemWe),  32'(e_we));
      if (owner != 0) begin
         chk("mem_addr",  bus.MEMARB_MemAddr,  e_addr);
         chk("mem_wdata", bus.MEMARB_MemWdata, e_wdata);
      end
      chk("if_done",  32'(bus.MEMARB_IfDone), 32'(e_if_done));
      chk("d_done",   32'(bus.MEMARB_DDone),  32'(e_d_done));
      chk("if_rdata", bus.MEMARB_IfRdata, e_if_rdata);
      chk("d_rdata",  bus.MEMARB_DRdata,  e_d_rdata);
      chk("err",      32'(bus.MEMARB_Err),    32'(e_err));
   endtask

   task automatic tick();
      bit sm, sf;
      @(negedge clk);
      sm = (mw | mr) & ~e_d_done;
      sf = (if_req & ~e_if_done) | sm;
      chk("stall_m", 32'(bus.MEMARB_StallM), 32'(sm));
      chk("stall_f", 32'(bus.MEMARB_StallF), 32'(sf));
      @(posedge clk);
      #1;
      model_step();
      check_outputs();
   endtask

   task automatic drive_random();
      int sel;
      if (!(if_req && !last_if_done)) begin
         if_req  = ($urandom_range(0, 2) != 0);
         if_addr = $urandom;
      end
      if (!((mw | mr) && !last_d_done)) begin
         sel = $urandom_range(0, 4);
         mr  = (sel == 1) || (sel == 3);
         mw  = (sel == 2) || (sel == 3);
         alu = $urandom;
         wd  = $urandom;
      end
      ack   = ($urandom_range(0, 2) == 0);
      rdata = $urandom;
   endtask

   initial begin
      int guard;
      clk = 0;
      rst_n = 0;
      clear_inputs();
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_req",   32'(bus.MEMARB_MemReq), 32'h0);
      chk("rst_we",    32'(bus.MEMARB_MemWe),  32'h0);
      chk("rst_addr",  bus.MEMARB_MemAddr, 32'h0);
      chk("rst_ddone", 32'(bus.MEMARB_DDone), 32'h0);
      chk("rst_err",   32'(bus.MEMARB_Err),   32'h0);
      rst_n = 1;

      // load with late ack
      alu = 32'h40; mr = 1;
      tick();
      chk("ld_req",   32'(bus.MEMARB_MemReq), 32'h1);
      chk("ld_addr",  bus.MEMARB_MemAddr, 32'h40);
      chk("ld_we",    32'(bus.MEMARB_MemWe), 32'h0);
      chk("ld_stall", 32'(bus.MEMARB_StallM), 32'h1);
      tick();
      tick();
      ack = 1; rdata = 32'hDEADBEEF;
      tick();
      ack = 0;
      chk("ld_done",  32'(bus.MEMARB_DDone), 32'h1);
      chk("ld_rdata", bus.MEMARB_DRdata, 32'hDEADBEEF);
      chk("ld_unstall", 32'(bus.MEMARB_StallM), 32'h0);
      mr = 0;
      tick();
      chk("ld_pulse", 32'(bus.MEMARB_DDone), 32'h0);

      // simultaneous store and fetch
      if_req = 1; if_addr = 32'h100; mw = 1; alu = 32'h20; wd = 32'h55;
      tick();
      chk("st_we",    32'(bus.MEMARB_MemWe), 32'h1);
      chk("st_addr",  bus.MEMARB_MemAddr, 32'h20);
      chk("st_wdata", bus.MEMARB_MemWdata, 32'h55);
      ack = 1; rdata = $urandom;
      tick();
      ack = 0;
      chk("st_done",   32'(bus.MEMARB_DDone), 32'h1);
      chk("st_bubble", 32'(bus.MEMARB_MemReq), 32'h0);
      chk("st_stallf", 32'(bus.MEMARB_StallF), 32'h1);
      mw = 0;
      tick();
      chk("fe_req",  32'(bus.MEMARB_MemReq), 32'h1);
      chk("fe_addr", bus.MEMARB_MemAddr, 32'h100);
      chk("fe_we",   32'(bus.MEMARB_MemWe), 32'h0);
      ack = 1; rdata = 32'hCAFEF00D;
      tick();
      ack = 0;
      chk("fe_done",  32'(bus.MEMARB_IfDone), 32'h1);
      chk("fe_rdata", bus.MEMARB_IfRdata, 32'hCAFEF00D);
      if_req = 0;
      tick();

      // fetch with no ack runs into the timeout
      if_req = 1; if_addr = 32'h200;
      tick();
      for (int i = 0; i < TIMEOUT - 1; i++) tick();
      chk("to_hold",  32'(bus.MEMARB_MemReq), 32'h1);
      tick();
      chk("to_done",  32'(bus.MEMARB_IfDone), 32'h1);
      chk("to_rdata", bus.MEMARB_IfRdata, 32'h0);
      chk("to_err",   32'(bus.MEMARB_Err), 32'h1);
      chk("to_idle",  32'(bus.MEMARB_MemReq), 32'h0);
      if_req = 0;
      repeat (5) tick();
      chk("to_sticky", 32'(bus.MEMARB_Err), 32'h1);

      for (int i = 0; i < 3000; i++) begin
         drive_random();
         tick();
      end

      // reset in the middle of a fetch grant; late ack must be ignored
      clear_inputs();
      guard = 0;
      while ((owner != 0 || e_if_done || e_d_done) && guard < 40) begin
         tick();
         guard++;
      end
      chk("idle_wait", 32'(guard < 40), 32'h1);
      if_req = 1; if_addr = 32'h300;
      tick();
      chk("mid_gnt", 32'(bus.MEMARB_MemReq), 32'h1);
      #2 rst_n = 0;
      #1;
      chk("mid_req",   32'(bus.MEMARB_MemReq), 32'h0);
      chk("mid_addr",  bus.MEMARB_MemAddr, 32'h0);
      chk("mid_err",   32'(bus.MEMARB_Err), 32'h0);
      chk("mid_rdata", bus.MEMARB_IfRdata, 32'h0);
      model_reset();
      if_req = 0;
      @(posedge clk);
      #1;
      rst_n = 1;
      ack = 1; rdata = 32'h12345678;
      tick();
      ack = 0;
      chk("late_req",  32'(bus.MEMARB_MemReq), 32'h0);
      chk("late_done", 32'(bus.MEMARB_IfDone), 32'h0);
      tick();
      chk("late_rdata", bus.MEMARB_IfRdata, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
